// File: rtl/fc_pkg.sv
// Shared dimensions, weight type and fetch FSM encoding for the
// fully-connected layer weight streaming path.
package fc_pkg;

    localparam int NUM_IN     = 400;
    localparam int NUM_OUT    = 120;
    localparam int FIFO_DEPTH = 2;

    typedef logic signed [7:0] weight_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_fetch_fifo.sv
// Two-entry weight buffer between the synchronous ROM and the consumer.
// Head and count come straight from flops, so push never reaches pop combinationally.
module fc_fetch_fifo
    import fc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  weight_t    push_data,
    input  logic       pop,
    output logic [1:0] count,
    output weight_t    head
);

    weight_t    mem_q [FIFO_DEPTH];
    weight_t    mem_d [FIFO_DEPTH];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fc_weight_fetcher.sv
// Streams the full NUM_OUT x NUM_IN weight matrix from an external synchronous
// ROM to a valid/ready consumer, row-major, one word per cycle when unstalled.
module fc_weight_fetcher #(
    parameter  int NUM_IN    = fc_pkg::NUM_IN,
    parameter  int NUM_OUT   = fc_pkg::NUM_OUT,
    parameter  int NUM_WORDS = NUM_IN * NUM_OUT,
    localparam int ADDR_W    = fc_pkg::width_of(NUM_WORDS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic [ADDR_W-1:0]    rom_addr,
    input  fc_pkg::weight_t      rom_q,
    output fc_pkg::weight_t      w_data,
    output logic                 w_valid,
    input  logic                 w_ready,
    output logic                 w_last_row,
    output logic                 w_last,
    output logic                 done,
    output fc_pkg::fetch_state_e dbg_state,
    output logic [1:0]           dbg_fifo_count
);

    import fc_pkg::*;

    localparam int                COL_W     = width_of(NUM_IN);
    localparam int                ROW_W     = width_of(NUM_OUT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(NUM_IN - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(NUM_OUT - 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              inflight_q, inflight_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;

    logic [1:0]        fifo_count;
    weight_t           fifo_head;
    logic              fifo_valid;
    logic              xfer;
    logic              at_last_col;
    logic              at_last_word;
    logic [2:0]        occupancy;
    logic              can_issue;

    // Handshake: a word moves when w_valid && w_ready at a rising edge; while
    // w_valid is high and w_ready low, data and flags hold until accepted.
    assign fifo_valid   = (fifo_count != 2'd0);
    assign xfer         = fifo_valid & w_ready;
    assign at_last_col  = (col_q == LAST_COL);
    assign at_last_word = at_last_col && (row_q == LAST_ROW);

    // Words already buffered plus the one returning from the ROM, minus the
    // one leaving now; a new read is allowed only if a slot is guaranteed.
    assign occupancy = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, xfer};
    assign can_issue = (occupancy <= 3'd1);

    fc_fetch_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (rom_q),
        .pop       (xfer),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        inflight_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        col_d      = col_q;
        row_d      = row_q;

        case (state_q)
            ST_IDLE: begin
                // The done cycle is still IDLE but must not relaunch a stream.
                if (start && !done_q) begin
                    state_d = ST_FETCH;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            ST_FETCH: begin
                if (can_issue) begin
                    inflight_d = 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (xfer) begin
            if (at_last_word) begin
                col_d   = '0;
                row_d   = '0;
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else if (at_last_col) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            col_q      <= col_d;
            row_q      <= row_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign rom_addr       = addr_q;
    assign w_valid        = fifo_valid;
    assign w_data         = fifo_valid ? fifo_head : '0;
    assign w_last_row     = fifo_valid & at_last_col;
    assign w_last         = fifo_valid & at_last_word;
    assign dbg_state      = state_q;
    assign dbg_fifo_count = fifo_count;

endmodule
